// File: rtl/dec_ddep_det.sv
// Decode-stage data-dependency detector: tracks EX/MEM/WB writers and a multi-cycle divider.
// Optional macro DDEP_FWD_EN: EX/MEM forwarding exists, so only load-use and divider hazards stall.
module dec_ddep_det #(
    parameter int RW          = 5,
    parameter int MDIV_CYCLES = 4,
    parameter int CW          = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dec_valid_i,
    input  logic [RW-1:0] dec_rs1_i,
    input  logic          dec_rs1_en_i,
    input  logic [RW-1:0] dec_rs2_i,
    input  logic          dec_rs2_en_i,
    input  logic [RW-1:0] dec_rd_i,
    input  logic          dec_wen_i,
    input  logic          dec_is_load_i,
    input  logic          dec_is_mdiv_i,
    input  logic          stall_dec_i,
    input  logic          flush_i,
    output logic          ddep_conflict_o,
    output logic          issue_o,
    output logic          mdiv_busy_o
);

    logic          rdy;
    logic          ex_vld, ex_ld, mem_vld, mem_ld, wb_vld, wb_ld;
    logic [RW-1:0] ex_rd, mem_rd, wb_rd, mrd;
    logic [CW-1:0] cnt;
    logic          mvld;
    logic          ex_load;
    logic          hit_ex, hit_mem, hit_wb, hit_div;
    logic          load_use, div_raw, div_struct, div_waw, base_conf;

    function automatic logic src_hit(input logic v, input logic [RW-1:0] a,
                                     input logic [RW-1:0] r1, input logic e1,
                                     input logic [RW-1:0] r2, input logic e2);
        return v && (a != '0) && ((e1 && (r1 == a)) || (e2 && (r2 == a)));
    endfunction

    assign hit_ex  = src_hit(ex_vld,  ex_rd,  dec_rs1_i, dec_rs1_en_i, dec_rs2_i, dec_rs2_en_i);
    assign hit_mem = src_hit(mem_vld, mem_rd, dec_rs1_i, dec_rs1_en_i, dec_rs2_i, dec_rs2_en_i);
    assign hit_wb  = src_hit(wb_vld,  wb_rd,  dec_rs1_i, dec_rs1_en_i, dec_rs2_i, dec_rs2_en_i);
    assign hit_div = src_hit(mvld,    mrd,    dec_rs1_i, dec_rs1_en_i, dec_rs2_i, dec_rs2_en_i);

    assign mdiv_busy_o = (cnt != '0);

    assign load_use   = ex_ld && hit_ex;
    assign div_raw    = mdiv_busy_o && hit_div;
    assign div_struct = mdiv_busy_o && dec_is_mdiv_i;
    assign div_waw    = mdiv_busy_o && mvld && dec_wen_i && (dec_rd_i == mrd);
    assign base_conf  = load_use || div_raw || div_struct || div_waw;

`ifdef DDEP_FWD_EN
    assign ddep_conflict_o = rdy && dec_valid_i && base_conf;
`else
    assign ddep_conflict_o = rdy && dec_valid_i && (base_conf || hit_ex || hit_mem || hit_wb);
`endif

    // rdy keeps issue low for the first cycle after reset release
    assign issue_o = rdy && dec_valid_i && !stall_dec_i && !flush_i;
    assign ex_load = issue_o && dec_wen_i && (dec_rd_i != '0) && !dec_is_mdiv_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy     <= 1'b0;
            ex_vld  <= 1'b0;
            ex_ld   <= 1'b0;
            ex_rd   <= '0;
            mem_vld <= 1'b0;
            mem_ld  <= 1'b0;
            mem_rd  <= '0;
            wb_vld  <= 1'b0;
            wb_ld   <= 1'b0;
            wb_rd   <= '0;
        end else begin
            rdy     <= 1'b1;
            ex_vld  <= ex_load;
            ex_ld   <= ex_load && dec_is_load_i;
            ex_rd   <= dec_rd_i;
            // a flush kills the instruction currently in EX before it reaches MEM
            mem_vld <= ex_vld && !flush_i;
            mem_ld  <= ex_ld && !flush_i;
            mem_rd  <= ex_rd;
            wb_vld  <= mem_vld;
            wb_ld   <= mem_ld;
            wb_rd   <= mem_rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            mrd  <= '0;
            mvld <= 1'b0;
        end else if (issue_o && dec_is_mdiv_i) begin
            cnt  <= CW'(MDIV_CYCLES);
            mrd  <= dec_rd_i;
            mvld <= dec_wen_i && (dec_rd_i != '0);
        end else if (cnt != '0) begin
            cnt  <= cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_dec_ddep_det.sv
// Directed table-driven bench for dec_ddep_det; stall_dec_i is closed through the detector's own request.
module tb_dec_ddep_det;

`ifdef DDEP_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic       r, v, e1, e2, wn, ld, md, xs, fl;
        logic [4:0] s1, s2, rd;
        logic       c, cx, i, fwc, b;
    } vec_t;

    vec_t vecs[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dec_valid = 1'b0, rs1_en = 1'b0, rs2_en = 1'b0, wen = 1'b0;
    logic       is_load = 1'b0, is_mdiv = 1'b0, xstall = 1'b0, flush = 1'b0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       stall_dec, conflict, issue, busy;
    int         n_pass = 0, n_total = 0;

    assign stall_dec = conflict | xstall;

    always #5 clk = ~clk;

    dec_ddep_det dut (
        .clk(clk), .rst(rst),
        .dec_valid_i(dec_valid),
        .dec_rs1_i(rs1), .dec_rs1_en_i(rs1_en),
        .dec_rs2_i(rs2), .dec_rs2_en_i(rs2_en),
        .dec_rd_i(rd), .dec_wen_i(wen),
        .dec_is_load_i(is_load), .dec_is_mdiv_i(is_mdiv),
        .stall_dec_i(stall_dec), .flush_i(flush),
        .ddep_conflict_o(conflict), .issue_o(issue), .mdiv_busy_o(busy)
    );

    task automatic add(input logic r, input logic v, input logic [4:0] s1, input logic e1,
                       input logic [4:0] s2, input logic e2, input logic [4:0] d,
                       input logic wn, input logic ld, input logic md, input logic xs,
                       input logic fl, input logic c, input logic cx, input logic i,
                       input logic fwc, input logic b);
        vec_t t;
        t.r = r; t.v = v; t.s1 = s1; t.e1 = e1; t.s2 = s2; t.e2 = e2; t.rd = d;
        t.wn = wn; t.ld = ld; t.md = md; t.xs = xs; t.fl = fl;
        t.c = c; t.cx = cx; t.i = i; t.fwc = fwc; t.b = b;
        vecs.push_back(t);
    endtask

    task automatic idle(input logic b);
        add(0,0, 0,0, 0,0, 0,0,0,0, 0,0, 0,0,0,0, b);
    endtask

    task automatic drive(input vec_t t);
        rst = t.r; dec_valid = t.v; rs1 = t.s1; rs1_en = t.e1; rs2 = t.s2; rs2_en = t.e2;
        rd = t.rd; wen = t.wn; is_load = t.ld; is_mdiv = t.md; xstall = t.xs; flush = t.fl;
    endtask

    task automatic chk(input string nm, input int k, input logic act, input logic exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s step %0d: got %0b expected %0b", nm, k, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t t;
        logic ec, ei;
        // reset held with garbage decode, then first cycle after release
        repeat (3) add(1,1, 3,1, 5,1, 3,1,1,1, 0,0, 0,0,0,0, 0);
        add(0,1, 3,1, 5,1, 3,1,1,0, 0,0, 0,0,0,0, 0);
        idle(0);
        // load r3 then reader of r3
        add(0,1, 0,0, 0,0, 3,1,1,0, 0,0, 0,0,1,0, 0);
        add(0,1, 3,1, 0,0, 0,0,0,0, 0,0, 1,0,0,0, 0);
        add(0,1, 3,1, 0,0, 0,0,0,0, 0,0, 1,0,0,1, 0);
        add(0,1, 3,1, 0,0, 0,0,0,0, 0,0, 1,0,0,1, 0);
        add(0,1, 3,1, 0,0, 0,0,0,0, 0,0, 0,0,1,0, 0);
        // ALU r7 then reader via rs2
        add(0,1, 0,0, 0,0, 7,1,0,0, 0,0, 0,0,1,0, 0);
        repeat (3) add(0,1, 0,0, 7,1, 0,0,0,0, 0,0, 1,0,0,1, 0);
        add(0,1, 0,0, 7,1, 0,0,0,0, 0,0, 0,0,1,0, 0);
        // source enables and dec_valid qualify the match
        add(0,1, 0,0, 0,0, 8,1,0,0, 0,0, 0,0,1,0, 0);
        add(0,1, 8,0, 8,0, 0,0,0,0, 0,0, 0,0,1,0, 0);
        add(0,0, 8,1, 0,0, 0,0,0,0, 0,0, 0,0,0,0, 0);
        idle(0);
        // div r5 then reader of r5
        add(0,1, 0,0, 0,0, 5,1,0,1, 0,0, 0,0,1,0, 0);
        repeat (4) add(0,1, 5,1, 0,0, 0,0,0,0, 0,0, 1,0,0,0, 1);
        add(0,1, 5,1, 0,0, 0,0,0,0, 0,0, 0,0,1,0, 0);
        // back-to-back divides, then WAW against the running divide
        add(0,1, 0,0, 0,0, 6,1,0,1, 0,0, 0,0,1,0, 0);
        repeat (4) add(0,1, 0,0, 0,0, 10,1,0,1, 0,0, 1,0,0,0, 1);
        add(0,1, 0,0, 0,0, 10,1,0,1, 0,0, 0,0,1,0, 0);
        add(0,1, 0,0, 0,0, 10,1,0,0, 0,0, 1,0,0,0, 1);
        add(0,1, 0,0, 0,0, 11,1,0,0, 0,0, 0,0,1,0, 1);
        idle(1); idle(1); idle(0);
        // register zero
        add(0,1, 0,0, 0,0, 0,1,1,0, 0,0, 0,0,1,0, 0);
        add(0,1, 0,1, 0,1, 0,0,0,0, 0,0, 0,0,1,0, 0);
        add(0,1, 0,0, 0,0, 0,1,0,1, 0,0, 0,0,1,0, 0);
        add(0,1, 0,1, 0,1, 0,0,0,0, 0,0, 0,0,1,0, 1);
        add(0,1, 0,0, 0,0, 12,1,0,1, 0,0, 1,0,0,0, 1);
        idle(1); idle(1); idle(0);
        // flush kills the load in EX
        add(0,1, 0,0, 0,0, 9,1,1,0, 0,0, 0,0,1,0, 0);
        add(0,1, 9,1, 0,0, 0,0,0,0, 0,1, 0,1,0,0, 0);
        add(0,1, 9,1, 0,0, 0,0,0,0, 0,0, 0,0,1,0, 0);
        // external stall: the writer must not enter EX
        add(0,1, 0,0, 0,0, 13,1,0,0, 1,0, 0,0,0,0, 0);
        add(0,1, 13,1, 0,0, 0,0,0,0, 0,0, 0,0,1,0, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            t = vecs[k];
            drive(t);
            #2;
            ec = (FWD && t.fwc) ? 1'b0 : t.c;
            ei = (FWD && t.fwc) ? 1'b1 : t.i;
            if (!t.cx) chk("conflict", k, conflict, ec);
            chk("issue", k, issue, ei);
            chk("busy", k, busy, t.b);
            step();
        end

        // asynchronous reset in the middle of a divide
        t = vecs[0];
        t.r = 0; t.v = 1; t.s1 = 0; t.e1 = 0; t.s2 = 0; t.e2 = 0;
        t.rd = 14; t.wn = 1; t.ld = 0; t.md = 1; t.xs = 0; t.fl = 0;
        drive(t);
        #2;
        chk("rdiv_issue", 0, issue, 1'b1);
        step();
        t.md = 0; t.wn = 0; t.rd = 0; t.s1 = 14; t.e1 = 1;
        drive(t);
        step();
        step();
        #2;
        chk("rdiv_busy_cnt2", 1, busy, 1'b1);
        chk("rdiv_raw_cnt2", 1, conflict, 1'b1);
        rst = 1'b1;
        #1;
        chk("rdiv_busy_async", 2, busy, 1'b0);
        chk("rdiv_conf_async", 2, conflict, 1'b0);
        chk("rdiv_issue_async", 2, issue, 1'b0);
        step();
        rst = 1'b0;
        #2;
        chk("rel_issue", 3, issue, 1'b0);
        chk("rel_busy", 3, busy, 1'b0);
        chk("rel_conf", 3, conflict, 1'b0);
        step();
        #2;
        chk("post_conf", 4, conflict, 1'b0);
        chk("post_issue", 4, issue, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
